// File: rtl/dm_responder.sv
// Wait-stated data-memory slave: accepts one word-addressed read/write per
// req/ack handshake, commits on the edge into RESP and pulses ack for one cycle.
module dm_responder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: the initiator raises req with we/addr/wdata/be and holds it until
  // it sees the one-cycle ack; the request fields are sampled only in IDLE, and
  // req must drop (or carry a new request) in the cycle after ack.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              err_q;

  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic              in_range;
  logic [IDX_W-1:0]  c_idx;

  logic [31:0] mem [DEPTH];

  // With no wait states the commit happens on the sampling edge itself, so
  // the live inputs are used instead of the request registers.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    c_addr    = addr_q;
    c_we      = we_q;
    c_wdata   = wdata_q;
    c_be      = be_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_nxt = S_RESP;
            commit    = rst;
            c_addr    = addr;
            c_we      = we;
            c_wdata   = wdata;
            c_be      = be;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
          commit    = rst;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_range  = (32'(c_addr) < DEPTH);
  assign c_idx     = c_addr[IDX_W-1:0];
  assign ack       = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign err       = (state == S_RESP) && err_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        be_q    <= be;
        cnt     <= 4'(WAIT);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= !in_range;
        if (!c_we) begin
          rdata <= in_range ? mem[c_idx] : 32'h0;
        end
      end
    end
  end

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (commit && c_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (WAIT=2/DEPTH=512, WAIT=0,
// WAIT=4) driven one at a time, with a reference memory and expected queue.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_v;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  wire  [2:0]  ack_v;
  wire  [2:0]  err_v;
  wire  [2:0]  busy_v;
  wire  [31:0] rdata_v [3];
  wire  [1:0]  st_v [3];

  int checks   = 0;
  int failures = 0;
  int dep [3]  = '{512, 1024, 1024};
  int wt  [3]  = '{2, 0, 4};

  logic [31:0] mdl_mem [3][1024];
  logic [31:0] mdl_rd  [3];
  logic [32:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  dm_responder #(.ADDR_W(10), .DEPTH(512), .WAIT(2)) u_a (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0]), .dbg_state(st_v[0]));

  dm_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT(0)) u_b (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1]), .dbg_state(st_v[1]));

  dm_responder #(.ADDR_W(10), .DEPTH(1024), .WAIT(4)) u_c (
    .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2]), .dbg_state(st_v[2]));

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int s, input logic w, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] b);
    logic e;
    e = (int'(a) >= dep[s]);
    if (e) begin
      if (!w) mdl_rd[s] = 32'h0;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl_mem[s][a][8*i +: 8] = d[8*i +: 8];
    end else begin
      mdl_rd[s] = mdl_mem[s][a];
    end
    exp_q.push_back({e, mdl_rd[s]});
  endtask

  task automatic check_resp(input int s, input string tag);
    logic [32:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, " err/rdata"}, {31'd0, err_v[s], rdata_v[s]}, {31'd0, exp});
    end
  endtask

  // ---------------- driver ----------------
  task automatic txn(input int s, input logic w, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit scramble, input string tag);
    int n;
    bit got;
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b; req_v[s] = 1'b1;
    model_push(s, w, a, d, b);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        addr = a ^ 10'h003; wdata = ~d; be = ~b;
      end
      if (ack_v[s]) got = 1'b1;
    end
    chk({tag, " ack"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({tag, " latency"}, 64'(n), 64'(wt[s] + 1));
      chk({tag, " busy"}, {63'd0, busy_v[s]}, 64'd1);
      check_resp(s, tag);
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    req_v[s] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle ack/err/busy"}, {61'd0, ack_v[s], err_v[s], busy_v[s]}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; req_v = 3'b000; we = 1'b0; addr = '0; wdata = '0; be = '0;
    for (int s = 0; s < 3; s++) mdl_rd[s] = 32'h0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d ack/err/busy", s), {61'd0, ack_v[s], err_v[s], busy_v[s]}, 64'd0);
      chk($sformatf("reset%0d rdata", s), {32'd0, rdata_v[s]}, 64'd0);
      chk($sformatf("reset%0d state", s), {62'd0, st_v[s]}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // write then read
    txn(0, 1'b1, 10'h004, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr4");
    txn(0, 1'b0, 10'h004, 32'h0,         4'h0, 1'b0, "rd4");

    // byte enables, including be=0
    txn(0, 1'b1, 10'h007, 32'h1122_3344, 4'hF,    1'b0, "wr7");
    txn(0, 1'b1, 10'h007, 32'hAABB_CCDD, 4'b0101, 1'b0, "wr7be");
    txn(0, 1'b0, 10'h007, 32'h0,         4'h0,    1'b0, "rd7a");
    txn(0, 1'b1, 10'h007, 32'h9999_9999, 4'h0,    1'b0, "wr7be0");
    txn(0, 1'b0, 10'h007, 32'h0,         4'h0,    1'b0, "rd7b");

    // out of range with DEPTH=512
    txn(0, 1'b1, 10'h000, 32'h0BAD_F00D, 4'hF, 1'b0, "wr0");
    txn(0, 1'b1, 10'h200, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr200");
    txn(0, 1'b0, 10'h200, 32'h0,         4'h0, 1'b0, "rd200");
    txn(0, 1'b0, 10'h000, 32'h0,         4'h0, 1'b0, "rd0");

    // inputs scrambled during WAIT must be ignored
    txn(0, 1'b1, 10'h009, 32'h5A5A_1234, 4'hF, 1'b1, "wr9scr");
    txn(0, 1'b0, 10'h009, 32'h0,         4'h0, 1'b1, "rd9scr");

    // random word traffic on the WAIT=2 instance
    for (int k = 0; k < 6; k++) begin
      logic [9:0]  ra;
      logic [31:0] rd;
      ra = 10'(32 + k);
      rd = $urandom;
      txn(0, 1'b1, ra, rd, 4'(1 + $urandom_range(0, 14)), 1'b0, "rndwr");
      txn(0, 1'b0, ra, 32'h0, 4'h0, 1'b0, "rndrd");
    end

    // WAIT=0 back-to-back reads with req held high
    txn(1, 1'b1, 10'h001, 32'h0101_A001, 4'hF, 1'b0, "b_wr1");
    txn(1, 1'b1, 10'h002, 32'h0202_B002, 4'hF, 1'b0, "b_wr2");
    @(negedge clk);
    we = 1'b0; addr = 10'h001; req_v[1] = 1'b1;
    model_push(1, 1'b0, 10'h001, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("b2b first ack", {62'd0, ack_v[1], busy_v[1]}, 64'd3);
    check_resp(1, "b2b first");
    @(negedge clk);
    addr = 10'h002;
    model_push(1, 1'b0, 10'h002, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("b2b gap ack", {63'd0, ack_v[1]}, 64'd0);
    @(posedge clk); #1;
    chk("b2b second ack", {62'd0, ack_v[1], busy_v[1]}, 64'd3);
    check_resp(1, "b2b second");
    @(negedge clk);
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b after ack", {62'd0, ack_v[1], busy_v[1]}, 64'd0);

    // reset during WAIT on the WAIT=4 instance
    txn(2, 1'b1, 10'h003, 32'h0000_0000, 4'hF, 1'b0, "c_wr3");
    txn(2, 1'b1, 10'h005, 32'h0000_0055, 4'hF, 1'b0, "c_wr5");
    txn(2, 1'b0, 10'h005, 32'h0,         4'h0, 1'b0, "c_rd5");
    @(negedge clk);
    we = 1'b1; addr = 10'h003; wdata = 32'h1234_5678; be = 4'hF; req_v[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst busy before", {63'd0, busy_v[2]}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst ack/busy", {62'd0, ack_v[2], busy_v[2]}, 64'd0);
    chk("rst rdata", {32'd0, rdata_v[2]}, 64'd0);
    chk("rst state", {62'd0, st_v[2]}, 64'd0);
    req_v[2] = 1'b0;
    for (int s = 0; s < 3; s++) mdl_rd[s] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    txn(2, 1'b0, 10'h003, 32'h0, 4'h0, 1'b0, "c_rd3");

    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
